// File: rtl/serial_parity_pkg.sv
// serial_parity_pkg: FSM state encoding and default frame width shared by the receiver files.
package serial_parity_pkg;
  localparam int DEFAULT_DATA_W = 8;
  typedef enum logic [1:0] {IDLE, DATA, PAR, DONE} state_t;
endpackage

// File: rtl/shift_reg_en.sv
// shift_reg_en: enabled shift register; new bits enter at the MSB so an LSB-first stream lands in order.
module shift_reg_en #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         en,
  input  logic         d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) q <= '0;
    else if (en) q <= {d, q[W-1:1]};
endmodule

// File: rtl/serial_parity_rx.sv
// serial_parity_rx: start bit, DATA_W bits LSB first, even parity; Z pulses one cycle per frame.
// Define SERIAL_PARITY_RX_ERR_CNT_EN to add the saturating err_cnt output.
module serial_parity_rx
  import serial_parity_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              CP,
  input  logic              CI_n,
  input  logic              x,
  input  logic              vld,
  output logic [DATA_W-1:0] data,
  output logic              Z,
  output logic              perr,
  output logic              busy
`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);
  localparam int CW = $clog2(DATA_W + 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] sr;
  logic last, take;
  assign last = cnt == CW'(DATA_W - 1);
  assign take = state == PAR && vld;
  assign Z    = state == DONE;
  assign busy = state == DATA || state == PAR;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (vld && x) ? DATA : IDLE;
      DATA:    state_nx = (vld && last) ? PAR : DATA;
      PAR:     state_nx = vld ? DONE : PAR;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge CP or negedge CI_n)
    if (!CI_n) state <= IDLE;
    else state <= state_nx;
  // counter sits at zero outside DATA, so it is clear on every entry to DATA
  always_ff @(posedge CP or negedge CI_n)
    if (!CI_n) cnt <= '0;
    else cnt <= (state == DATA) ? cnt + CW'(vld) : '0;
  shift_reg_en #(.W(DATA_W)) u_sr (
    .clk  (CP),
    .clr_n(CI_n),
    .en   (state == DATA && vld),
    .d    (x),
    .q    (sr)
  );
  always_ff @(posedge CP or negedge CI_n)
    if (!CI_n) begin
      data <= '0;
      perr <= 1'b0;
    end else if (take) begin
      data <= sr;
      perr <= ^sr ^ x;
    end
`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
  always_ff @(posedge CP or negedge CI_n)
    if (!CI_n) err_cnt <= '0;
    else if (Z && perr && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
`endif
endmodule

// File: tb/tb_serial_parity_rx.sv
// tb_serial_parity_rx: drives frames with optional vld stalls and checks against frame-level expectations.
module tb_serial_parity_rx;
  localparam int W = 8;
  logic CP = 1'b0, CI_n = 1'b1, x = 1'b0, vld = 1'b0;
  logic [W-1:0] data;
  logic Z, perr, busy;
  int checks = 0, errors = 0;
  logic [W-1:0] exp_data = '0;
  logic exp_perr = 1'b0;
`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
  logic [7:0] err_cnt;
  int exp_err = 0;
`endif

  serial_parity_rx #(.DATA_W(W)) dut (
    .CP  (CP),
    .CI_n(CI_n),
    .x   (x),
    .vld (vld),
    .data(data),
    .Z   (Z),
    .perr(perr),
    .busy(busy)
`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
    ,
    .err_cnt(err_cnt)
`endif
  );

  always #5 CP = ~CP;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: back-to-back bits, 1: vld toggles every cycle, 2: random stalls
  task automatic send_frame(input logic [W-1:0] w, input logic p, input int mode);
    logic [W+1:0] bits;
    logic ep;
    int g;
    bits = {p, w, 1'b1};
    ep = 1'(($countones(w) + int'(p)) % 2);
    for (int i = 0; i < W + 2; i++) begin
      g = mode == 0 ? 0 : mode == 1 ? int'(i > 0) : int'($urandom_range(0, 2));
      for (int k = 0; k < g; k++) begin
        vld = 1'b0;
        x = 1'($urandom);
        @(negedge CP);
        chk("stall_busy", 32'(busy), 32'(i > 0));
        chk("stall_z", 32'(Z), 0);
      end
      vld = 1'b1;
      x = bits[i];
      @(negedge CP);
      if (i <= W) begin
        chk("busy", 32'(busy), 1);
        chk("z_mid", 32'(Z), 0);
        chk("data_hold", 32'(data), 32'(exp_data));
        chk("perr_hold", 32'(perr), 32'(exp_perr));
      end
    end
    exp_data = w;
    exp_perr = ep;
    chk("z_done", 32'(Z), 1);
    chk("data", 32'(data), 32'(w));
    chk("perr", 32'(perr), 32'(ep));
    chk("busy_done", 32'(busy), 0);
    // a start-like strobe during the done cycle must be ignored
    vld = 1'b1;
    x = 1'b1;
    @(negedge CP);
    vld = 1'b0;
    chk("z_after", 32'(Z), 0);
    chk("busy_after", 32'(busy), 0);
`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
    if (ep) exp_err = exp_err < 255 ? exp_err + 1 : 255;
    chk("err_cnt", 32'(err_cnt), 32'(exp_err));
`endif
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_data"}, 32'(data), 0);
    chk({tag, "_z"}, 32'(Z), 0);
    chk({tag, "_perr"}, 32'(perr), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
    chk({tag, "_err"}, 32'(err_cnt), 0);
`endif
  endtask

  initial begin
    logic [W-1:0] w;
    #1 CI_n = 1'b0;
    @(negedge CP);
    @(negedge CP);
    check_cleared("reset");
    CI_n = 1'b1;
    @(negedge CP);

    send_frame(8'hA5, 1'b0, 0);
    send_frame(8'h01, 1'b0, 0);
    send_frame(8'h3C, 1'b0, 1);

    for (int i = 0; i < 20; i++) begin
      vld = 1'b1;
      x = 1'b0;
      @(negedge CP);
      chk("idle_z", 32'(Z), 0);
      chk("idle_busy", 32'(busy), 0);
    end
    send_frame(8'hFF, 1'b0, 0);

    vld = 1'b1;
    x = 1'b1;
    @(negedge CP);
    for (int i = 0; i < 4; i++) begin
      x = 1'($urandom);
      @(negedge CP);
    end
    chk("pre_rst_busy", 32'(busy), 1);
    #2 CI_n = 1'b0;
    #1 check_cleared("mid_rst");
    exp_data = '0;
    exp_perr = 1'b0;
`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
    exp_err = 0;
`endif
    @(negedge CP);
    check_cleared("rst_hold");
    vld = 1'b0;
    CI_n = 1'b1;
    @(negedge CP);
    check_cleared("rst_rel");
    send_frame(8'h5A, 1'b0, 0);

    for (int n = 0; n < 30; n++) begin
      w = W'($urandom);
      send_frame(w, 1'($urandom), int'($urandom_range(0, 2)));
    end

`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
    for (int n = 0; n < 260; n++) begin
      w = W'($urandom);
      send_frame(w, 1'(($countones(w) + 1) % 2), 0);
    end
    chk("err_sat", 32'(err_cnt), 255);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_parity_rx.md
SERIAL_PARITY_RX -- requirements
Module: serial_parity_rx

Interface
REQ-001 Parameter: DATA_W, 8, number of data bits per frame (legal range 2..16).
REQ-002 Port: CP  input  1  clock; all state changes on its rising edge.
REQ-003 Port: CI_n  input  1  asynchronous, active-low reset.
REQ-004 Port: x  input  1  serial line bit, sampled only when vld=1.
REQ-005 Port: vld  input  1  bit strobe; one serial bit per CP cycle with vld=1.
REQ-006 Port: data  output  DATA_W  last received data word, registered.
REQ-007 Port: Z  output  1  one-cycle frame-done pulse.
REQ-008 Port: perr  output  1  parity error flag for the frame reported by Z; valid when Z=1.
REQ-009 Port: busy  output  1  high while a frame is being received (DATA or PAR state).
REQ-010 Port (only with ERR_CNT_EN): err_cnt  output  8  saturating count of frames with perr=1.

Function
REQ-011 Frame format: start bit x=1, then DATA_W data bits LSB first, then one even-parity bit.
REQ-012 FSM states SHALL be IDLE, DATA, PAR and DONE.
REQ-013 IDLE: vld=1 with x=1 goes to DATA; vld=1 with x=0 is ignored; vld=0 holds the state.
REQ-014 DATA: each vld=1 cycle shifts x into the shift register MSB-ward and increments the bit counter; after DATA_W bits the FSM goes to PAR.
REQ-015 PAR: on vld=1, perr_next = XOR(received bits) XOR x. On the next edge the FSM enters DONE, data loads, and perr loads.
REQ-016 DONE lasts exactly one cycle with Z=1, then returns to IDLE. A vld=1 during DONE is ignored and SHALL NOT start a frame.
REQ-017 Latency: Z rises on the first CP edge after the parity bit is sampled.
REQ-018 vld=0 in any state except DONE stalls the FSM, the counter and the shift register with no data loss.
REQ-019 data and perr SHALL hold their values until the next DONE; they do not change mid-frame.
REQ-020 The bit counter is $clog2(DATA_W+1) bits wide and clears on entry to DATA.

Reset
REQ-021 CI_n=0 SHALL asynchronously force: state=IDLE, data=0, Z=0, perr=0, busy=0, shift register=0, counter=0 and err_cnt=0.
REQ-022 Reset mid-frame SHALL abort the frame with no Z pulse. Reception resumes with the first start bit after CI_n returns high.

Configuration
REQ-023 Macro SERIAL_PARITY_RX_ERR_CNT_EN defined: err_cnt is present and increments in each DONE cycle with perr=1, saturating at 255.
REQ-024 Macro undefined: the err_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-025 Shared package serial_parity_pkg SHALL hold the FSM state typedef (IDLE, DATA, PAR, DONE) and the localparam DEFAULT_DATA_W=8.
REQ-026 One sub-module, shift_reg_en (parameterised width, enable, async active-low clear), SHALL implement the data shift register. The FSM, counter and parity logic SHALL stay in the top level.

Verification
REQ-027 Reset, then frame 1, 0xA5 (LSB first), parity 0 -> Z pulse 1 cycle after the parity bit, data=0xA5, perr=0.
REQ-028 Frame 1, 0x01, parity 0 -> data=0x01, perr=1. With ERR_CNT_EN, err_cnt increments from 0 to 1.
REQ-029 Frame 0x3C with vld toggling 1/0 every cycle -> data=0x3C, perr=0, Z pulse exactly once, busy high throughout reception.
REQ-030 Idle line x=0 with vld=1 for 20 cycles, then a valid 0xFF frame with parity 0 -> no spurious Z; then data=0xFF, perr=0.
REQ-031 Assert CI_n=0 after 4 data bits of a frame -> all outputs 0 and no Z; a following 0x5A frame with parity 0 yields data=0x5A, perr=0.
REQ-032 With ERR_CNT_EN, send 260 frames with bad parity -> err_cnt saturates at 255.
